// File: rtl/dmem_pkg.sv
// Shared constants and types for the handshaked RV32I data memory.
package dmem_pkg;

  // RV32I load/store funct3 encodings
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Access size as carried in funct3[1:0]
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  // Wait-state counter width (0..15 extra cycles)
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // funct3 values that have no meaning for the given direction.
  // Stores only exist as SB/SH/SW; funct3 011 would be a 64-bit access.
  function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
    if (we) begin
      return f3[2] || (f3[1:0] == 2'b11);
    end
    return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for RV32I loads and stores: strobes, store-data
// replication onto the lanes, load extraction/extension, alignment check.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_raw,
  output logic [3:0]  o_strobe,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata,
  output logic        o_misalign
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic        w_sign;

  // Extension is signed for LB/LH, unsigned for LBU/LHU.
  assign w_sign = ~i_funct3[2];

  // Select the addressed byte and halfword from the raw RAM word.
  always_comb begin
    w_byte = i_raw[7:0];
    case (i_addr_lo)
      2'd1:    w_byte = i_raw[15:8];
      2'd2:    w_byte = i_raw[23:16];
      2'd3:    w_byte = i_raw[31:24];
      default: w_byte = i_raw[7:0];
    endcase
    w_half = i_addr_lo[1] ? i_raw[31:16] : i_raw[15:0];
  end

  // Per-size lane enables, lane-replicated store data, load result and alignment.
  always_comb begin
    o_strobe   = 4'b0000;
    o_wdata    = i_wdata;
    o_rdata    = '0;
    o_misalign = 1'b0;
    case (i_funct3[1:0])
      SZ_B: begin
        o_strobe = 4'b0001 << i_addr_lo;
        o_wdata  = {4{i_wdata[7:0]}};
        o_rdata  = {{24{w_sign & w_byte[7]}}, w_byte};
      end
      SZ_H: begin
        o_strobe   = i_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_wdata    = {2{i_wdata[15:0]}};
        o_rdata    = {{16{w_sign & w_half[15]}}, w_half};
        o_misalign = i_addr_lo[0];
      end
      SZ_W: begin
        o_strobe   = 4'b1111;
        o_wdata    = i_wdata;
        o_rdata    = i_raw;
        o_misalign = (i_addr_lo != 2'b00);
      end
      default: begin
        o_strobe = 4'b0000;
      end
    endcase
  end

endmodule

// File: rtl/data_mem_hs.sv
// RV32I data memory with valid/ready request/response handshake,
// programmable wait states, byte-strobe writes and access trapping.
module data_mem_hs
  import dmem_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int MEM_WORDS   = 256,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err
);

  localparam int IDX_W = $clog2(MEM_WORDS);

  state_t                  r_state;
  logic [CNT_W-1:0]        r_cnt;
  logic                    r_we;
  logic [2:0]              r_funct3;
  logic [1:0]              r_addr_lo;
  logic [IDX_W-1:0]        r_idx;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic                    r_req_ready;
  logic                    r_rsp_valid;
  logic                    r_rsp_err;
  logic [DATA_WIDTH-1:0]   r_rsp_rdata;

  logic                    w_idle;
  logic                    w_accept;
  logic                    w_access;
  logic                    w_do_write;
  logic                    w_oob;
  logic                    w_fault;
  logic [ADDR_WIDTH-3:0]   w_word_addr;
  logic [IDX_W-1:0]        w_req_idx;
  logic [2:0]              w_al_funct3;
  logic [1:0]              w_al_addr_lo;
  logic [3:0]              w_strobe;
  logic [31:0]             w_wdata_sh;
  logic [31:0]             w_load_data;
  logic                    w_misalign;
  logic [31:0]             w_rd_word;

  assign w_idle      = (r_state == ST_IDLE);
  assign w_accept    = w_idle && req_valid;
  assign w_word_addr = req_addr[ADDR_WIDTH-1:2];
  assign w_req_idx   = req_addr[IDX_W+1:2];
  // No wrap-around: any word address beyond the array is a fault.
  assign w_oob       = (w_word_addr >= (ADDR_WIDTH-2)'(MEM_WORDS));

  // In IDLE the aligner checks the incoming request; afterwards it
  // works on the captured request to build strobes and load data.
  assign w_al_funct3  = w_idle ? req_funct3    : r_funct3;
  assign w_al_addr_lo = w_idle ? req_addr[1:0] : r_addr_lo;

  dmem_lane_align u_align (
    .i_funct3   (w_al_funct3),
    .i_addr_lo  (w_al_addr_lo),
    .i_wdata    (r_wdata),
    .i_raw      (w_rd_word),
    .o_strobe   (w_strobe),
    .o_wdata    (w_wdata_sh),
    .o_rdata    (w_load_data),
    .o_misalign (w_misalign)
  );

  assign w_fault    = w_misalign || f3_illegal(req_we, req_funct3) || w_oob;
  assign w_access   = (r_state == ST_WAIT) && (r_cnt == '0);
  // Reset asserted on the access edge must suppress the pending store.
  assign w_do_write = rst_n && w_access && r_we;

  // One byte-wide bank per lane; the word is read at the accept edge so the
  // registered read is ready by the time the wait states have elapsed.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] r_bank [MEM_WORDS];
    logic [7:0] r_rd_byte;

    // Byte-lane write on the access edge, registered read on accept.
    always_ff @(posedge clk) begin
      if (w_do_write && w_strobe[gi]) begin
        r_bank[r_idx] <= w_wdata_sh[8*gi +: 8];
      end
      if (w_accept) begin
        r_rd_byte <= r_bank[w_req_idx];
      end
    end

    assign w_rd_word[8*gi +: 8] = r_rd_byte;
  end

  // Request/response FSM with registered handshake and response outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_we        <= 1'b0;
      r_funct3    <= '0;
      r_addr_lo   <= '0;
      r_idx       <= '0;
      r_wdata     <= '0;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_we        <= req_we;
            r_funct3    <= req_funct3;
            r_addr_lo   <= req_addr[1:0];
            r_idx       <= w_req_idx;
            r_wdata     <= req_wdata;
            r_cnt       <= CNT_W'(WAIT_CYCLES);
            r_req_ready <= 1'b0;
            if (w_fault) begin
              r_state     <= ST_RESP;
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= 1'b1;
              r_rsp_rdata <= '0;
            end else begin
              r_state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else begin
            r_state     <= ST_RESP;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= r_we ? '0 : w_load_data;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            r_state     <= ST_IDLE;
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b1;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_req_ready <= 1'b1;
          r_rsp_valid <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

endmodule
